// File: rtl/snn_io_ctrl.sv
`default_nettype none
// ============================================================================
// snn_io_ctrl : UART <-> SNN core sequencer (pixel unpack, launch, ASCII reply)
// Revision 1.0
// ============================================================================
module snn_io_ctrl #(
  parameter  int IMG_BITS    = 784,
  parameter  int TIMEOUT_CYC = 5000000,
  parameter  int SEND_CRLF   = 1,
  localparam int NBYTES      = (IMG_BITS + 7) / 8,
  localparam int ADDR_W      = $clog2(IMG_BITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              start,
  input  logic              done,
  input  logic [3:0]        digit,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_rdy,
  output logic              busy,
  output logic [7:0]        led
);

  localparam int              BC_W      = $clog2(NBYTES + 1);
  localparam int              TM_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0]      LAST_BIT  = 3'((IMG_BITS - 1) % 8);
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NBYTES - 1);
  localparam logic [TM_W-1:0] TM_LAST   = TM_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UNPACK  = 3'd1,
    WAITB   = 3'd2,
    LAUNCH  = 3'd3,
    COMPUTE = 3'd4,
    TXCHR   = 3'd5,
    TXWAIT  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [7:0]        hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [TM_W-1:0]   timer_q, timer_d;
  logic              frame_err_q, frame_err_d;
  logic              tmo_q, tmo_d;
  logic              ovr_q, ovr_d;
  logic              res_valid_q, res_valid_d;
  logic [3:0]        digit_q, digit_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [1:0]        chr_idx_q, chr_idx_d;
  logic              txw_first_q, txw_first_d;

  logic w_last_pix;
  logic w_byte_end;

  assign w_last_pix = (byte_cnt_q == LAST_BYTE) && (bit_cnt_q == LAST_BIT);
  assign w_byte_end = (bit_cnt_q == 3'd7);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    timer_d     = timer_q;
    frame_err_d = frame_err_q;
    tmo_d       = tmo_q;
    ovr_d       = ovr_q;
    res_valid_d = res_valid_q;
    digit_d     = digit_q;
    tx_data_d   = tx_data_q;
    chr_idx_d   = chr_idx_q;
    txw_first_d = txw_first_q;
    wr_en       = 1'b0;
    start       = 1'b0;
    tx_start    = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_rdy) begin
          shreg_d     = rx_data;
          byte_cnt_d  = '0;
          bit_cnt_d   = '0;
          pix_cnt_d   = '0;
          timer_d     = '0;
          hold_full_d = 1'b0;
          frame_err_d = 1'b0;
          state_d     = UNPACK;
        end
      end

      UNPACK: begin
        wr_en     = 1'b1;
        shreg_d   = {1'b0, shreg_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        pix_cnt_d = pix_cnt_q + ADDR_W'(1);
        if (w_last_pix) begin
          // Any byte still buffered or arriving now has no frame to go into.
          if (rx_rdy || hold_full_q) begin
            ovr_d       = 1'b1;
            frame_err_d = 1'b1;
          end
          pix_cnt_d   = '0;
          bit_cnt_d   = '0;
          byte_cnt_d  = '0;
          hold_full_d = 1'b0;
          state_d     = LAUNCH;
        end else if (w_byte_end) begin
          byte_cnt_d = byte_cnt_q + BC_W'(1);
          if (hold_full_q) begin
            shreg_d     = hold_q;
            hold_d      = rx_data;
            hold_full_d = rx_rdy;
          end else if (rx_rdy) begin
            shreg_d = rx_data;
          end else begin
            timer_d = '0;
            state_d = WAITB;
          end
        end else if (rx_rdy) begin
          if (hold_full_q) begin
            ovr_d       = 1'b1;
            frame_err_d = 1'b1;
          end else begin
            hold_d      = rx_data;
            hold_full_d = 1'b1;
          end
        end
      end

      WAITB: begin
        timer_d = timer_q + TM_W'(1);
        if (rx_rdy) begin
          shreg_d = rx_data;
          timer_d = '0;
          state_d = UNPACK;
        end else if (timer_q == TM_LAST) begin
          tmo_d      = 1'b1;
          pix_cnt_d  = '0;
          byte_cnt_d = '0;
          bit_cnt_d  = '0;
          timer_d    = '0;
          state_d    = IDLE;
        end
      end

      LAUNCH: begin
        start = 1'b1;
        if (!frame_err_q) begin
          tmo_d = 1'b0;
          ovr_d = 1'b0;
        end
        if (rx_rdy) ovr_d = 1'b1;
        state_d = COMPUTE;
      end

      COMPUTE: begin
        if (rx_rdy) ovr_d = 1'b1;
        if (done) begin
          digit_d     = digit;
          res_valid_d = 1'b1;
          tx_data_d   = {4'h0, digit} + 8'h30;
          chr_idx_d   = 2'd0;
          state_d     = TXCHR;
        end
      end

      TXCHR: begin
        if (tx_rdy) begin
          tx_start    = 1'b1;
          txw_first_d = 1'b1;
          state_d     = TXWAIT;
        end
      end

      TXWAIT: begin
        // tx_rdy may not have fallen yet in the first cycle after tx_start.
        if (txw_first_q) begin
          txw_first_d = 1'b0;
        end else if (tx_rdy) begin
          if ((SEND_CRLF != 0) && (chr_idx_q != 2'd2)) begin
            chr_idx_d = chr_idx_q + 2'd1;
            tx_data_d = (chr_idx_q == 2'd0) ? 8'h0D : 8'h0A;
            state_d   = TXCHR;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      pix_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      timer_q     <= '0;
      frame_err_q <= 1'b0;
      tmo_q       <= 1'b0;
      ovr_q       <= 1'b0;
      res_valid_q <= 1'b0;
      digit_q     <= '0;
      tx_data_q   <= '0;
      chr_idx_q   <= '0;
      txw_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      timer_q     <= timer_d;
      frame_err_q <= frame_err_d;
      tmo_q       <= tmo_d;
      ovr_q       <= ovr_d;
      res_valid_q <= res_valid_d;
      digit_q     <= digit_d;
      tx_data_q   <= tx_data_d;
      chr_idx_q   <= chr_idx_d;
      txw_first_q <= txw_first_d;
    end
  end

  assign wr_addr = pix_cnt_q;
  assign wr_data = shreg_q[0];
  assign tx_data = tx_data_q;
  assign busy    = (state_q != IDLE);
  assign led     = {res_valid_q, ovr_q, tmo_q, busy, digit_q};

endmodule
`default_nettype wire

// File: tb/tb_snn_io_ctrl.sv
`default_nettype none
// tb_snn_io_ctrl : scoreboard bench driving two snn_io_ctrl configurations
// (u_a: 16-pixel frame, no CR/LF; u_b: 12-pixel frame with CR/LF).
module tb_snn_io_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rx_rdy   [2];
  logic [7:0] rx_data  [2];
  logic       wr_en    [2];
  logic [3:0] wr_addr  [2];
  logic       wr_data  [2];
  logic       start_w  [2];
  logic       done     [2];
  logic [3:0] digit    [2];
  logic       tx_start [2];
  logic [7:0] tx_data  [2];
  logic       tx_rdy   [2];
  logic       busy     [2];
  logic [7:0] led      [2];

  snn_io_ctrl #(.IMG_BITS(16), .TIMEOUT_CYC(100), .SEND_CRLF(0)) u_a (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy[0]), .rx_data(rx_data[0]),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .start(start_w[0]), .done(done[0]), .digit(digit[0]),
    .tx_start(tx_start[0]), .tx_data(tx_data[0]), .tx_rdy(tx_rdy[0]),
    .busy(busy[0]), .led(led[0])
  );

  snn_io_ctrl #(.IMG_BITS(12), .TIMEOUT_CYC(100), .SEND_CRLF(1)) u_b (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy[1]), .rx_data(rx_data[1]),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .start(start_w[1]), .done(done[1]), .digit(digit[1]),
    .tx_start(tx_start[1]), .tx_data(tx_data[1]), .tx_rdy(tx_rdy[1]),
    .busy(busy[1]), .led(led[1])
  );

  // UART transmitter model: busy for 5 cycles after each tx_start.
  logic [2:0] txc [2];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txc[0] <= 3'd0;
      txc[1] <= 3'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (tx_start[i] === 1'b1) txc[i] <= 3'd5;
        else if (txc[i] != 3'd0)  txc[i] <= txc[i] - 3'd1;
      end
    end
  end
  assign tx_rdy[0] = (txc[0] == 3'd0);
  assign tx_rdy[1] = (txc[1] == 3'd0);

  typedef struct {
    int inst;
    int a;
    int d;
  } ev_t;

  ev_t wq[$];
  ev_t sq[$];
  ev_t tq[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int which, input int i, input int a, input int d);
    ev_t e;
    e.inst = i;
    e.a    = a;
    e.d    = d;
    case (which)
      0:       wq.push_back(e);
      1:       sq.push_back(e);
      default: tq.push_back(e);
    endcase
  endtask

  task automatic push_wr(input int i, input int base, input logic [7:0] b, input int n);
    for (int j = 0; j < n; j++) push_ev(0, i, base + j, int'(b[j]));
  endtask

  function automatic int outs(input int i);
    return int'({wr_en[i], wr_addr[i], wr_data[i], start_w[i], tx_start[i],
                 tx_data[i], busy[i], led[i]});
  endfunction

  task automatic to_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic rx(input int i, input logic [7:0] b);
    rx_rdy[i]  = 1'b1;
    rx_data[i] = b;
    @(negedge clk);
    rx_rdy[i] = 1'b0;
  endtask

  // Two-byte frame; the second byte arrives `gap` cycles into WAITB.
  task automatic frame(input int i, input logic [7:0] b0, input logic [7:0] b1,
                       input int n1, input int gap);
    push_wr(i, 0, b0, 8);
    rx(i, b0);
    repeat (8 + gap) @(negedge clk);
    push_wr(i, 8, b1, n1);
    push_ev(1, i, cyc + n1 + 1, 0);
    rx(i, b1);
  endtask

  // Returns at the first COMPUTE cycle, or with a failure if start never comes.
  task automatic launch_wait(input int i, output bit ok);
    int n = 0;
    while (start_w[i] !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    ok = (start_w[i] === 1'b1);
    chk("start_seen", int'(ok), 1);
    if (ok) @(negedge clk);
  endtask

  task automatic pulse_done(input int i, input logic [3:0] dg);
    push_ev(2, i, int'(8'h30 + {4'h0, dg}), 0);
    if (i == 1) begin
      push_ev(2, i, 8'h0D, 0);
      push_ev(2, i, 8'h0A, 0);
    end
    done[i]  = 1'b1;
    digit[i] = dg;
    @(negedge clk);
    done[i]  = 1'b0;
    digit[i] = 4'h0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (busy[i] !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", int'(busy[i]), 0);
  endtask

  task automatic core(input int i, input logic [3:0] dg, input int chk_bit,
                      input logic chk_val, input bit crx);
    bit ok;
    launch_wait(i, ok);
    if (!ok) return;
    if (chk_bit >= 0) chk("led_compute", int'(led[i][chk_bit]), int'(chk_val));
    if (crx) rx(i, 8'h77);
    pulse_done(i, dg);
    wait_idle(i);
  endtask

  always @(negedge clk) begin : mon
    ev_t e;
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i] === 1'b1) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL wr u%0d: unexpected write addr=%0d data=%0d", i, wr_addr[i], wr_data[i]);
        end else begin
          e = wq.pop_front();
          if (e.inst != i || e.a != int'(wr_addr[i]) || e.d != int'(wr_data[i])) begin
            errors++;
            $display("FAIL wr u%0d: got addr=%0d data=%0d, expected u%0d addr=%0d data=%0d",
                     i, wr_addr[i], wr_data[i], e.inst, e.a, e.d);
          end
        end
      end
      if (start_w[i] === 1'b1) begin
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL start u%0d: unexpected start at cyc %0d", i, cyc);
        end else begin
          e = sq.pop_front();
          if (e.inst != i || e.a != cyc) begin
            errors++;
            $display("FAIL start u%0d: got cyc %0d, expected u%0d cyc %0d", i, cyc, e.inst, e.a);
          end
        end
      end
      if (tx_start[i] === 1'b1) begin
        checks++;
        if (tq.size() == 0) begin
          errors++;
          $display("FAIL tx u%0d: unexpected tx_start data=0x%0h", i, tx_data[i]);
        end else begin
          e = tq.pop_front();
          if (e.inst != i || e.a != int'(tx_data[i]) || tx_rdy[i] !== 1'b1) begin
            errors++;
            $display("FAIL tx u%0d: got data=0x%0h rdy=%0d, expected u%0d data=0x%0h rdy=1",
                     i, tx_data[i], tx_rdy[i], e.inst, e.a);
          end
        end
      end
    end
  end

  initial begin
    int  t0;
    bit  ok;
    for (int i = 0; i < 2; i++) begin
      rx_rdy[i]  = 1'b0;
      rx_data[i] = 8'h00;
      done[i]    = 1'b0;
      digit[i]   = 4'h0;
    end
    repeat (3) @(negedge clk);
    chk("rst_outs_a", outs(0), 0);
    chk("rst_outs_b", outs(1), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic 16-pixel frame, digit 7, single character reply.
    frame(0, 8'hA5, 8'h3C, 8, 2);
    core(0, 4'd7, -1, 1'b0, 1'b0);
    chk("led_basic", int'(led[0]), 8'h87);

    // Partial frame times out after 100 idle cycles in WAITB.
    push_wr(0, 0, 8'h0F, 8);
    t0 = cyc;
    rx(0, 8'h0F);
    to_cyc(t0 + 108);
    chk("tmo_busy_last", int'(busy[0]), 1);
    @(negedge clk);
    chk("tmo_busy_after", int'(busy[0]), 0);
    chk("tmo_led", int'(led[0]), 8'hA7);
    frame(0, 8'h01, 8'h80, 8, 0);
    core(0, 4'd9, 5, 1'b0, 1'b0);
    chk("led_tmo_clear", int'(led[0]), 8'h89);

    // Three back-to-back bytes: two unpacked, third dropped.
    t0 = cyc;
    push_wr(0, 0, 8'hFF, 8);
    push_wr(0, 8, 8'h00, 8);
    push_ev(1, 0, t0 + 17, 0);
    rx(0, 8'hFF);
    rx(0, 8'h00);
    rx(0, 8'h55);
    core(0, 4'd2, 6, 1'b1, 1'b0);
    chk("led_ovr", int'(led[0]), 8'hC2);
    frame(0, 8'h12, 8'h34, 8, 1);
    core(0, 4'd5, 6, 1'b0, 1'b1);
    chk("led_ovr_compute", int'(led[0]), 8'hC5);

    // Reset in the middle of UNPACK.
    push_wr(0, 0, 8'hA5, 4);
    rx(0, 8'hA5);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_unpack_a", outs(0), 0);
    chk("rst_unpack_b", outs(1), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame(0, 8'h3C, 8'hA5, 8, 3);
    core(0, 4'd0, 6, 1'b0, 1'b0);
    chk("led_after_rst", int'(led[0]), 8'h80);

    // 12-pixel frame with CR/LF reply.
    frame(1, 8'hFF, 8'hFF, 4, 2);
    core(1, 4'd3, -1, 1'b0, 1'b0);
    chk("led_crlf", int'(led[1]), 8'h83);

    // Reset while waiting for the transmitter.
    frame(1, 8'h5A, 8'hF6, 4, 0);
    launch_wait(1, ok);
    if (ok) begin
      push_ev(2, 1, 8'h38, 0);
      done[1]  = 1'b1;
      digit[1] = 4'd8;
      @(negedge clk);
      done[1]  = 1'b0;
      digit[1] = 4'h0;
      @(negedge clk);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_txwait_b", outs(1), 0);
    chk("rst_txwait_a", outs(0), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    frame(1, 8'h81, 8'h0E, 4, 5);
    core(1, 4'd1, 7, 1'b0, 1'b0);
    chk("led_b_after_rst", int'(led[1]), 8'h81);

    repeat (5) @(negedge clk);
    chk("wr_left", wq.size(), 0);
    chk("start_left", sq.size(), 0);
    chk("tx_left", tq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
